// File: rtl/axis_stream_gen_p.sv
// Parametrised AXI-Stream source: FWFT FIFO with packet-length tlast, replay
// (recirculate) mode, sticky overflow and tvalid hold across op_en drops.
module axis_stream_gen_p #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned PKT_LEN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     push,
  input  logic                     op_en,
  input  logic                     replay,
  input  logic [PKT_LEN_WIDTH-1:0] pkt_len,
  output logic [DATA_WIDTH-1:0]    tdata,
  output logic                     tvalid,
  input  logic                     tready,
  output logic                     tlast,
  output logic [$clog2(DEPTH):0]   buff_count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (PKT_LEN_WIDTH > AW + 1) ? PKT_LEN_WIDTH : AW + 1;

  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [AW:0]              r_count;
  logic [PKT_LEN_WIDTH-1:0] r_beat_cnt;
  logic [PKT_LEN_WIDTH-1:0] r_len;
  logic                     r_hold;
  logic                     r_overflow;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_tvalid;
  logic                     w_tlast;
  logic                     w_accept;
  logic                     w_wr_en;
  logic [DATA_WIDTH-1:0]    w_wr_data;
  logic [AW:0]              w_count_d;
  logic [PKT_LEN_WIDTH-1:0] w_len;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (AW + 1)'(DEPTH));
  assign w_tvalid = !w_empty && (op_en || r_hold);
  assign w_accept = w_tvalid && tready;

  // Replay recirculates the head to the tail; external pushes are ignored.
  assign w_wr_en   = replay ? w_accept : (push && (!w_full || w_accept));
  assign w_wr_data = replay ? r_mem[r_rd_ptr] : din;

  // Length is sampled live on the first beat, then held for the rest of the packet.
  assign w_len = (r_beat_cnt == '0) ? pkt_len : r_len;

  always_comb begin
    w_tlast = 1'b0;
    if (w_len != '0) begin
      w_tlast = w_tvalid && (r_beat_cnt == w_len - PKT_LEN_WIDTH'(1));
    end else if (replay) begin
      w_tlast = w_tvalid && (CW'(r_beat_cnt) == CW'(r_count) - CW'(1));
    end else begin
      w_tlast = w_tvalid && (r_count == (AW + 1)'(1));
    end
  end

  always_comb begin
    w_count_d = r_count;
    if (!replay) begin
      if (w_wr_en && !w_accept) begin
        w_count_d = r_count + (AW + 1)'(1);
      end else if (!w_wr_en && w_accept) begin
        w_count_d = r_count - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_beat_cnt <= '0;
      r_len      <= '0;
      r_hold     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_hold  <= w_tvalid && !tready;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_accept) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        if (r_beat_cnt == '0) begin
          r_len <= pkt_len;
        end
        r_beat_cnt <= w_tlast ? '0 : r_beat_cnt + PKT_LEN_WIDTH'(1);
      end
      if (!replay && push && w_full && !w_accept) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign tdata      = r_mem[r_rd_ptr];
  assign tvalid     = w_tvalid;
  assign tlast      = w_tlast;
  assign buff_count = r_count;
  assign empty      = w_empty;
  assign full       = w_full;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_axis_stream_gen_p.sv
// Scoreboard bench for axis_stream_gen_p: expected beats are queued as data is
// pushed and compared when the DUT hands them over.
module tb_axis_stream_gen_p;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned Depth     = 16;
  localparam int unsigned PktW      = 8;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } beat_t;

  logic                    clk;
  logic                    rst;
  logic [DataWidth-1:0]    din;
  logic                    push;
  logic                    op_en;
  logic                    replay;
  logic [PktW-1:0]         pkt_len;
  logic [DataWidth-1:0]    tdata;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [$clog2(Depth):0]  buff_count;
  logic                    empty;
  logic                    full;
  logic                    overflow;

  beat_t sb_q[$];
  int    n_checks;
  int    n_fails;

  axis_stream_gen_p #(
    .DATA_WIDTH   (DataWidth),
    .DEPTH        (Depth),
    .PKT_LEN_WIDTH(PktW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .push      (push),
    .op_en     (op_en),
    .replay    (replay),
    .pkt_len   (pkt_len),
    .tdata     (tdata),
    .tvalid    (tvalid),
    .tready    (tready),
    .tlast     (tlast),
    .buff_count(buff_count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept happens on the following posedge; inputs only change just after posedges.
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      if (sb_q.size() == 0) begin
        check_eq("beat_with_empty_scoreboard", sb_q.size(), 1);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        check_eq("tdata", 32'(tdata), 32'(e.data));
        check_eq("tlast", 32'(tlast), 32'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DataWidth-1:0] d);
    din  = d;
    push = 1'b1;
    tick();
    push = 1'b0;
  endtask

  task automatic expect_beat(input logic [DataWidth-1:0] d, input logic l);
    beat_t e;
    e.data = d;
    e.last = l;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check_eq("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    op_en   = 1'b0;
    tready  = 1'b0;
    replay  = 1'b0;
    push    = 1'b0;
    pkt_len = '0;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    din      = '0;
    do_reset();

    check_eq("rst_tvalid", 32'(tvalid), 0);
    check_eq("rst_tlast", 32'(tlast), 0);
    check_eq("rst_empty", 32'(empty), 1);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_count", 32'(buff_count), 0);
    check_eq("rst_overflow", 32'(overflow), 0);

    // Basic FWFT drain with pkt_len=0
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    check_eq("t1_count", 32'(buff_count), 4);
    check_eq("t1_tvalid_off", 32'(tvalid), 0);
    expect_beat(8'h11, 1'b0);
    expect_beat(8'h22, 1'b0);
    expect_beat(8'h33, 1'b0);
    expect_beat(8'h44, 1'b1);
    op_en  = 1'b1;
    tready = 1'b1;
    wait_drain(20);
    check_eq("t1_empty", 32'(empty), 1);

    // Overflow: DEPTH+1 pushes with no accepts
    do_reset();
    op_en = 1'b1;
    for (int i = 0; i < Depth; i++) begin
      push_word(8'(i));
    end
    check_eq("t2_full", 32'(full), 1);
    check_eq("t2_ovf_before", 32'(overflow), 0);
    push_word(8'h10);
    check_eq("t2_overflow", 32'(overflow), 1);
    check_eq("t2_count", 32'(buff_count), Depth);
    for (int i = 0; i < Depth; i++) begin
      expect_beat(8'(i), (i == Depth - 1));
    end
    tready = 1'b1;
    wait_drain(40);
    check_eq("t2_empty", 32'(empty), 1);
    check_eq("t2_overflow_sticky", 32'(overflow), 1);

    // pkt_len=3, change to 2 during second packet's 2nd beat
    do_reset();
    pkt_len = 8'd3;
    for (int i = 0; i < 7; i++) begin
      push_word(8'h30 + 8'(i));
    end
    expect_beat(8'h30, 1'b0);
    expect_beat(8'h31, 1'b0);
    expect_beat(8'h32, 1'b1);
    expect_beat(8'h33, 1'b0);
    expect_beat(8'h34, 1'b0);
    expect_beat(8'h35, 1'b1);
    expect_beat(8'h36, 1'b0);
    op_en  = 1'b1;
    tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) pkt_len = 8'd2;
      tick();
    end
    check_eq("t3_sb_done", sb_q.size(), 0);
    check_eq("t3_empty", 32'(empty), 1);

    // tvalid hold when op_en drops mid-beat
    do_reset();
    op_en = 1'b1;
    push_word(8'h5A);
    check_eq("t4_tvalid", 32'(tvalid), 1);
    tick();
    op_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t4_hold_tvalid", 32'(tvalid), 1);
      check_eq("t4_hold_tdata", 32'(tdata), 32'h5A);
    end
    expect_beat(8'h5A, 1'b1);
    tready = 1'b1;
    wait_drain(10);
    check_eq("t4_tvalid_after", 32'(tvalid), 0);

    // Replay mode with an ignored concurrent push
    do_reset();
    push_word(8'hA1);
    push_word(8'hB2);
    for (int i = 0; i < 3; i++) begin
      expect_beat(8'hA1, 1'b0);
      expect_beat(8'hB2, 1'b1);
    end
    replay = 1'b1;
    op_en  = 1'b1;
    tready = 1'b1;
    din    = 8'hEE;
    push   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("t5_count", 32'(buff_count), 2);
    end
    tready = 1'b0;
    op_en  = 1'b0;
    push   = 1'b0;
    check_eq("t5_sb_done", sb_q.size(), 0);
    check_eq("t5_overflow", 32'(overflow), 0);
    tick();
    check_eq("t5_count_final", 32'(buff_count), 2);
    replay = 1'b0;

    // Reset mid-packet, then a fresh 4-beat packet
    do_reset();
    pkt_len = 8'd4;
    for (int i = 0; i < 6; i++) begin
      push_word(8'h60 + 8'(i));
    end
    expect_beat(8'h60, 1'b0);
    expect_beat(8'h61, 1'b0);
    op_en  = 1'b1;
    tready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_eq("t6_rst_tvalid", 32'(tvalid), 0);
    check_eq("t6_rst_tlast", 32'(tlast), 0);
    check_eq("t6_rst_count", 32'(buff_count), 0);
    check_eq("t6_sb_done", sb_q.size(), 0);
    op_en  = 1'b0;
    tready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      push_word(8'h70 + 8'(i));
      expect_beat(8'h70 + 8'(i), (i == 3));
    end
    op_en  = 1'b1;
    tready = 1'b1;
    wait_drain(20);
    check_eq("t6_empty", 32'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
